uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one byte-wide UART transmitter among NUM_REQ result producers, such as several FIR channels.
- Arbitrates round-robin, captures the granted 16-bit word and serializes it as framed bytes: optional channel header, then LSB, then MSB.
- Sits between the FIR datapath outputs and the TxD transmitter, using the TxD_start/TxD_busy handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- HDR_EN, 1, 1 = send header byte {4'hA, ch[3:0]} before the data bytes; 0 = data bytes only.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- req  input  NUM_REQ  per-requester word-valid; held until ack.
- data_in  input  16*NUM_REQ  requester i word at [16*i+15:16*i].
- ack  output  NUM_REQ  one-cycle pulse: word of requester i captured.
- TxD_busy  input  1  transmitter busy.
- TxD_start  output  1  one-cycle start pulse to the transmitter.
- TxD_data  output  8  byte to transmit; stable from LOAD through WAIT.
- busy  output  1  high whenever the state is not IDLE.
- cur_ch  output  4  index of the channel granted last.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; ack=0, TxD_start=0, TxD_data=0, busy=0, cur_ch=0.
  - Holding register=0, byte counter=0.
  - Round-robin pointer=NUM_REQ-1, so channel 0 has top priority first.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- FSM states: IDLE, LOAD, SEND, GAP, WAIT.
- IDLE:
  - If req!=0, select the first set bit searching upward from pointer+1, wrapping modulo NUM_REQ.
  - On that edge:
    - hold <= data_in[ch]; cur_ch <= ch; pointer <= ch; ack[ch] <= 1 for exactly the next cycle.
    - byte counter <= 0 if HDR_EN, else 1.
    - Go to LOAD.
  - req=0 -> stay in IDLE.
- LOAD:
  - TxD_data <= the byte selected by the counter: 0 = header, 1 = hold[7:0], 2 = hold[15:8].
  - If TxD_busy=0 -> SEND; else stay in LOAD.
- SEND:
  - TxD_start=1 for exactly this one cycle.
  - Next state is GAP unconditionally.
- GAP:
  - One cycle that allows the transmitter to raise TxD_busy.
  - Next state is WAIT.
- WAIT:
  - While TxD_busy=1, stay.
  - When TxD_busy=0: if the counter is 2 -> IDLE; else increment the counter -> LOAD.
- Latency, HDR_EN=1, idle transmitter:
  - Capture edge at cycle 0.
  - First TxD_start high in cycle 2.
  - Minimum spacing between TxD_start pulses is 4 cycles plus transmitter busy time.
- While busy=1, req is ignored; no ack is issued.
  - A requester keeping req high after its ack is treated as a new request at the next IDLE arbitration.
- Simultaneous requests: exactly one ack bit is ever high.
  - A continuously requesting channel cannot be granted twice in a row while another req bit is set.
- Single requester: it is re-granted every frame; the pointer wraps correctly from NUM_REQ-1 to 0.
- TxD_busy already high in LOAD: TxD_start is withheld until busy=0; no byte is dropped or duplicated.
- Reset mid-frame: the frame is abandoned immediately and TxD_start falls.
  - The captured word is lost; the requester has already been acked, which is by design.
- Unused data_in bits of non-granted channels have no effect.

Test Plan:
- Reset, then req=4'b0001, data_in[15:0]=16'h1234, transmitter model busy for 10 cycles after each start:
  - ack[0] pulses one cycle.
  - Bytes A0, 34, 12 are sent, one TxD_start each.
  - busy returns to 0 after the third busy falls.
- HDR_EN=0, req=4'b0100, word 16'hBEEF:
  - Only bytes EF, BE are sent.
  - cur_ch=2; first TxD_start 2 cycles after the capture edge.
- req=4'b1111 held continuously, acked bit dropped and reasserted:
  - Grant order is 0,1,2,3,0,1.
  - Headers are A0,A1,A2,A3,A0,A1.
- Round-robin wrap: last grant ch3, then req=4'b1001 -> ch0 granted, not ch3.
- TxD_busy forced high while in LOAD for 20 cycles:
  - TxD_start stays 0 throughout.
  - It pulses once, 1 cycle after busy falls; TxD_data is unchanged.
- Assert rst=0 asynchronously mid-cycle, between LSB and MSB:
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release, the next req starts a fresh frame with header byte first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one byte-wide UART transmitter
// among NUM_REQ 16-bit producers; frames are [header], LSB, MSB.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter bit HDR_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [16*NUM_REQ-1:0] data_in,
    output logic [NUM_REQ-1:0]    ack,
    input  logic                  TxD_busy,
    output logic                  TxD_start,
    output logic [7:0]            TxD_data,
    output logic                  busy,
    output logic [3:0]            cur_ch
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        GAP,
        WAIT
    } state_t;

    state_t              state;
    logic [15:0]         hold;
    logic [1:0]          cnt;
    logic [3:0]          ptr;
    logic [3:0]          pick;
    logic                found;
    logic [NUM_REQ-1:0]  grant;
    logic [15:0]         sel_word;
    logic [7:0]          byte_sel;

    // Winner is the set bit closest above ptr, wrapping modulo NUM_REQ.
    always_comb begin : arb
        int best;
        best  = NUM_REQ;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] &&
                ((i + NUM_REQ - 1 - int'(ptr)) % NUM_REQ) < best) begin
                best  = (i + NUM_REQ - 1 - int'(ptr)) % NUM_REQ;
                pick  = 4'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        grant    = '0;
        sel_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == 4'(i)) begin
                grant[i] = found;
                sel_word = data_in[16*i +: 16];
            end
        end
    end

    always_comb begin
        unique case (cnt)
            2'd0:    byte_sel = {4'hA, cur_ch};
            2'd1:    byte_sel = hold[7:0];
            default: byte_sel = hold[15:8];
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            hold      <= '0;
            cnt       <= '0;
            ptr       <= 4'(NUM_REQ - 1);
            ack       <= '0;
            TxD_start <= 1'b0;
            TxD_data  <= '0;
            cur_ch    <= '0;
        end else begin
            ack       <= '0;
            TxD_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        hold   <= sel_word;
                        cur_ch <= pick;
                        ptr    <= pick;
                        ack    <= grant;
                        cnt    <= HDR_EN ? 2'd0 : 2'd1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    TxD_data <= byte_sel;
                    if (!TxD_busy) begin
                        TxD_start <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: state <= GAP;
                // gives the transmitter a cycle to raise TxD_busy
                GAP:  state <= WAIT;
                WAIT: begin
                    if (!TxD_busy) begin
                        if (cnt == 2'd2) begin
                            state <= IDLE;
                        end else begin
                            cnt   <= cnt + 2'd1;
                            state <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
